rrc_pam4_upsampler: RTL and testbench

- Symbol-rate front end placed directly upstream of the RRC pulse-shaping filter.
- Accepts 2-bit Gray-coded PAM4 symbols over a valid/ready handshake and buffers them in a small FIFO.
- Maps each symbol to a signed <1.6> level and zero-stuffs to OSR samples per symbol.
- Emits one sample every clock, matching the filter's continuous data_in stream.

---
 rtl/rrc_pam4_upsampler.sv | 135 +++++++++++++
 tb/tb_rrc_pam4_upsampler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rrc_pam4_upsampler.sv
// PAM4 symbol FIFO, Gray-to-level mapper and OSR zero-stuffer feeding the RRC filter.
// Define RRC_UPS_HOLD_EN for zero-order hold instead of zero-stuffing.
module rrc_pam4_upsampler #(
    parameter int WIDTH      = 7,
    parameter int OSR        = 4,
    parameter int AMP        = 48,
    parameter int FIFO_DEPTH = 4,
    parameter int PRIME      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sym_valid,
    input  logic [1:0]              sym_data,
    output logic                    sym_ready,
    output logic signed [WIDTH-1:0] data_out,
    output logic                    sym_strobe,
    output logic                    underrun,
    output logic                    active
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(OSR);

    localparam logic signed [WIDTH-1:0] LVL_PO = WIDTH'(AMP);
    localparam logic signed [WIDTH-1:0] LVL_PI = WIDTH'(AMP / 3);
    localparam logic signed [WIDTH-1:0] LVL_NI = WIDTH'(-(AMP / 3));
    localparam logic signed [WIDTH-1:0] LVL_NO = WIDTH'(-AMP);

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic signed [WIDTH-1:0] map_sym(input logic [1:0] s);
        case (s)
            2'b00:   map_sym = LVL_NO;
            2'b01:   map_sym = LVL_NI;
            2'b11:   map_sym = LVL_PI;
            default: map_sym = LVL_PO;
        endcase
    endfunction

    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    state_t                  state, state_nxt;
    logic [PW-1:0]           phase, phase_nxt;
    logic signed [WIDTH-1:0] dout_nxt;
    logic                    strobe_nxt, under_nxt;

    // Ready comes only from the registered count so it never combines with a same-cycle pop.
    assign sym_ready = !rst && (count < CW'(FIFO_DEPTH));
    assign push      = sym_valid && sym_ready;
    assign active    = (state == RUN);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sym_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        pop        = 1'b0;
        dout_nxt   = '0;
        strobe_nxt = 1'b0;
        under_nxt  = 1'b0;
        case (state)
            IDLE: begin
                phase_nxt = '0;
                if (en && count >= CW'(PRIME)) state_nxt = RUN;
            end
            RUN: begin
                if (phase == '0 && count == '0) begin
                    // Starved at a symbol boundary: drop out and wait to re-prime.
                    under_nxt = 1'b1;
                    state_nxt = IDLE;
                    phase_nxt = '0;
                end else begin
                    if (phase == '0) begin
                        pop        = 1'b1;
                        dout_nxt   = map_sym(mem[rd_ptr]);
                        strobe_nxt = 1'b1;
                    end else begin
`ifdef RRC_UPS_HOLD_EN
                        dout_nxt = data_out;
`else
                        dout_nxt = '0;
`endif
                    end
                    if (phase == PW'(OSR - 1)) begin
                        phase_nxt = '0;
                        if (!en) state_nxt = IDLE;
                    end else begin
                        phase_nxt = phase + PW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            data_out   <= '0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            data_out   <= dout_nxt;
            sym_strobe <= strobe_nxt;
            underrun   <= under_nxt;
        end
    end

endmodule

// File: tb/tb_rrc_pam4_upsampler.sv
// Scoreboard bench for rrc_pam4_upsampler: expected levels queued on accept, checked on sym_strobe.
module tb_rrc_pam4_upsampler;

    localparam int WIDTH = 7;
    localparam int OSR   = 4;
    localparam int AMP   = 48;
    localparam int DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    rst, en, sym_valid;
    logic [1:0]              sym_data;
    logic                    sym_ready, sym_strobe, underrun, active;
    logic signed [WIDTH-1:0] data_out;

    rrc_pam4_upsampler #(
        .WIDTH(WIDTH), .OSR(OSR), .AMP(AMP), .FIFO_DEPTH(DEPTH), .PRIME(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sym_valid(sym_valid), .sym_data(sym_data),
        .sym_ready(sym_ready), .data_out(data_out), .sym_strobe(sym_strobe),
        .underrun(underrun), .active(active)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0, n_under = 0, under_cyc = 0;
    int exp_q[$];
    int strobe_cyc[$];
    int acc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int lvl(input logic [1:0] s);
        case (s)
            2'b00:   return -AMP;
            2'b01:   return -(AMP / 3);
            2'b11:   return AMP / 3;
            default: return AMP;
        endcase
    endfunction

    // Output monitor: symbol samples against the scoreboard, gaps must be silent.
    always @(negedge clk) begin
        if (!rst) begin
            if (sym_strobe) begin
                strobe_cyc.push_back(cyc);
                chk("sb_avail", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("sample", data_out, exp_q.pop_front());
            end else begin
`ifndef RRC_UPS_HOLD_EN
                chk("zero_stuff", data_out, 0);
`endif
            end
            if (underrun) begin
                n_under++;
                under_cyc = cyc;
                chk("underrun_active", active, 0);
                chk("underrun_data", data_out, 0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [1:0] s);
        int  budget;
        bit  done;
        logic rdy;
        budget = 0;
        done = 0;
        sym_valid = 1'b1;
        sym_data  = s;
        while (!done) begin
            rdy = sym_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                exp_q.push_back(lvl(s));
                acc_cyc.push_back(cyc);
                done = 1;
            end else if (++budget > 200) begin
                chk("push_timeout", int'(sym_ready), 1);
                done = 1;
            end
        end
        sym_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int u0, n;
        rst = 1'b1; en = 1'b0; sym_valid = 1'b1; sym_data = 2'b10;

        // reset with valid held high
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_ready", sym_ready, 0);
            chk("rst_data", data_out, 0);
            chk("rst_strobe", sym_strobe, 0);
            chk("rst_active", active, 0);
        end
        rst = 1'b0; sym_valid = 1'b0;
        #1;
        chk("rst_count", int'(dut.count), 0);
        chk("ready_after_rst", sym_ready, 1);

        // mapping, zero-stuff, latency, underrun after drain
        cycles(2);
        en = 1'b1;
        acc_cyc.delete(); strobe_cyc.delete(); u0 = n_under;
        send_sym(2'b00); send_sym(2'b01); send_sym(2'b11); send_sym(2'b10);
        wait_drain(100);
        cycles(OSR + 2);
        chk("map_strobes", strobe_cyc.size(), 4);
        if (strobe_cyc.size() == 4) begin
            chk("first_latency", strobe_cyc[0] - acc_cyc[0], 2);
            for (int i = 1; i < 4; i++) chk("strobe_gap", strobe_cyc[i] - strobe_cyc[i-1], OSR);
            chk("underrun_phase", under_cyc - strobe_cyc[3], OSR);
        end
        chk("underrun_once", n_under - u0, 1);
        chk("idle_after_underrun", active, 0);

        // two symbols then starve, then resume
        acc_cyc.delete(); strobe_cyc.delete(); u0 = n_under;
        send_sym(2'b11); send_sym(2'b00);
        wait_drain(100);
        cycles(OSR + 2);
        chk("ur_strobes", strobe_cyc.size(), 2);
        chk("ur_once", n_under - u0, 1);
        chk("ur_inactive", active, 0);
        acc_cyc.delete(); strobe_cyc.delete();
        send_sym(2'b01);
        wait_drain(50);
        chk("resume_strobes", strobe_cyc.size(), 1);
        if (strobe_cyc.size() == 1) chk("resume_latency", strobe_cyc[0] - acc_cyc[0], 2);
        cycles(OSR + 2);

        // back-pressure: 8 symbols into a 4-deep FIFO
        en = 1'b0;
        acc_cyc.delete(); strobe_cyc.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) send_sym(2'(i));
            end
            begin
                cycles(8);
                chk("bp_accepts", acc_cyc.size(), 4);
                chk("bp_ready_low", sym_ready, 0);
                en = 1'b1;
            end
        join
        wait_drain(200);
        chk("bp_total", acc_cyc.size(), 8);
        if (acc_cyc.size() == 8)
            for (int i = 5; i < 8; i++) chk("bp_accept_gap", acc_cyc[i] - acc_cyc[i-1], OSR);
        chk("bp_strobes", strobe_cyc.size(), 8);
        cycles(OSR + 2);

        // en dropped mid-symbol: finish period, keep FIFO contents
        acc_cyc.delete(); strobe_cyc.delete();
        send_sym(2'b10); send_sym(2'b01); send_sym(2'b11);
        n = 0;
        while (strobe_cyc.size() == 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        en = 1'b0;
        cycles(1);
        chk("en_last_phase_active", active, 1);
        cycles(1);
        chk("en_idle_at_wrap", active, 0);
        cycles(10);
        chk("en_hold_strobes", strobe_cyc.size(), 1);
        chk("en_fifo_kept", int'(dut.count), 2);
        en = 1'b1;
        wait_drain(50);
        chk("en_resume_strobes", strobe_cyc.size(), 3);
        cycles(OSR + 2);

`ifdef RRC_UPS_HOLD_EN
        // zero-order hold
        send_sym(2'b10); send_sym(2'b00);
        n = 0;
        while (!sym_strobe && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 9; k++) begin
            chk("hold_data", data_out, (k == 8) ? 0 : (k < 4 ? AMP : -AMP));
            chk("hold_strobe", sym_strobe, int'(k == 0 || k == 4));
            @(negedge clk);
        end
        cycles(OSR + 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
